// File: rtl/led_pattern_sequencer.sv
// LED pattern sequencer: a prescaled step tick advances an 8-bit pattern
// (blink, rotate-left, bounce or binary count), and a small PWM stage
// scales brightness before the registered LED outputs.
module led_pattern_sequencer #(
   parameter int TICK_DIV = 12500000,
   parameter int PWM_BITS = 4
) (
   input  logic                CLK50MHz,
   input  logic                RST_N,
   input  logic [1:0]          MODE,
   input  logic                PAUSE,
   input  logic [PWM_BITS-1:0] BRIGHT,
   output logic [7:0]          LED,
   output logic                STEP
);

   typedef enum logic [1:0] {
      MODE_BLINK  = 2'b00,
      MODE_ROTATE = 2'b01,
      MODE_BOUNCE = 2'b10,
      MODE_COUNT  = 2'b11
   } mode_t;

   typedef enum logic {
      DIR_LEFT  = 1'b0,
      DIR_RIGHT = 1'b1
   } dir_t;

   localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

   logic [PRE_W-1:0]    prescaler;
   logic                tick;
   logic [PWM_BITS-1:0] pwm_cnt;
   logic                en;
   logic [7:0]          pattern;
   logic [7:0]          pattern_next;
   mode_t               mode_in;
   mode_t               mode_q;
   mode_t               mode_next;
   dir_t                dir;
   dir_t                dir_next;

   assign mode_in = mode_t'(MODE);

   // A paused prescaler holds its count, so a tick suppressed by PAUSE in the
   // terminal cycle is simply deferred to the first unpaused terminal cycle.
   assign tick = (prescaler == PRE_LAST) && !PAUSE;

   // Full-scale BRIGHT is forced fully on rather than 15/16 duty.
   assign en = (BRIGHT == {PWM_BITS{1'b1}}) || (pwm_cnt < BRIGHT);

   // Prescaler: counts 0..TICK_DIV-1 and wraps, frozen while paused.
   always_ff @(posedge CLK50MHz or negedge RST_N) begin
      if (!RST_N) begin
         prescaler <= '0;
      end else if (!PAUSE) begin
         if (prescaler == PRE_LAST) begin
            prescaler <= '0;
         end else begin
            prescaler <= prescaler + PRE_W'(1);
         end
      end
   end

   // PWM counter free-runs every clock, independent of PAUSE.
   always_ff @(posedge CLK50MHz or negedge RST_N) begin
      if (!RST_N) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + PWM_BITS'(1);
      end
   end

   // Pattern state register: pattern, latched mode and bounce direction.
   always_ff @(posedge CLK50MHz or negedge RST_N) begin
      if (!RST_N) begin
         pattern <= 8'h00;
         mode_q  <= MODE_BLINK;
         dir     <= DIR_LEFT;
      end else begin
         pattern <= pattern_next;
         mode_q  <= mode_next;
         dir     <= dir_next;
      end
   end

   // Next-state logic: on a tick, a new MODE loads its starting pattern
   // (no advance that step); otherwise the pattern advances per mode_q.
   always_comb begin
      pattern_next = pattern;
      mode_next    = mode_q;
      dir_next     = dir;
      if (tick) begin
         if (mode_in != mode_q) begin
            mode_next = mode_in;
            case (mode_in)
               MODE_BLINK:  pattern_next = 8'hFF;
               MODE_ROTATE: pattern_next = 8'h01;
               MODE_BOUNCE: begin
                  pattern_next = 8'h01;
                  dir_next     = DIR_LEFT;
               end
               MODE_COUNT:  pattern_next = 8'h00;
               default:     pattern_next = pattern;
            endcase
         end else begin
            case (mode_q)
               MODE_BLINK:  pattern_next = ~pattern;
               MODE_ROTATE: pattern_next = {pattern[6:0], pattern[7]};
               MODE_BOUNCE: begin
                  if (dir == DIR_LEFT) begin
                     if (pattern[7]) begin
                        dir_next     = DIR_RIGHT;
                        pattern_next = pattern >> 1;
                     end else begin
                        pattern_next = pattern << 1;
                     end
                  end else begin
                     if (pattern[0]) begin
                        dir_next     = DIR_LEFT;
                        pattern_next = pattern << 1;
                     end else begin
                        pattern_next = pattern >> 1;
                     end
                  end
               end
               MODE_COUNT:  pattern_next = pattern + 8'd1;
               default:     pattern_next = pattern;
            endcase
         end
      end
   end

   // Registered outputs: STEP marks the update cycle, LED follows one clock
   // later with the PWM gate applied.
   always_ff @(posedge CLK50MHz or negedge RST_N) begin
      if (!RST_N) begin
         LED  <= 8'h00;
         STEP <= 1'b0;
      end else begin
         LED  <= pattern & {8{en}};
         STEP <= tick;
      end
   end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer: the stimulus process queues the
// LED value expected after each STEP; the monitor pops and compares.
module tb_led_pattern_sequencer;

   localparam int TICK_DIV = 4;
   localparam int PWM_BITS = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [1:0]          mode;
   logic                pause;
   logic [PWM_BITS-1:0] bright;
   logic [7:0]          led;
   logic                step;

   logic [7:0] exp_q[$];
   int         tests_run = 0;
   int         tests_failed = 0;
   int         since_step = 0;
   int         gap_extra = 0;
   bit         led_due = 1'b0;

   logic [7:0] rot_tbl [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
   logic [7:0] bnc_tbl [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20,
                                8'h40, 8'h80, 8'h40, 8'h20, 8'h10, 8'h08,
                                8'h04, 8'h02, 8'h01, 8'h02};

   led_pattern_sequencer #(
      .TICK_DIV (TICK_DIV),
      .PWM_BITS (PWM_BITS)
   ) dut (
      .CLK50MHz (clk),
      .RST_N    (rst_n),
      .MODE     (mode),
      .PAUSE    (pause),
      .BRIGHT   (bright),
      .LED      (led),
      .STEP     (step)
   );

   // 100 MHz simulation clock stands in for the board clock.
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [7:0] actual,
                               input logic [7:0] required);
      tests_run++;
      if (actual !== required) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %02h, want %02h at %0t", name, actual, required, $time);
      end
   endtask

   task automatic apply_stimulus(input logic [1:0] m);
      mode = m;
   endtask

   // Wait until the monitor has consumed every queued expectation.
   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         tests_run++;
         tests_failed++;
         $display("[TB] FAIL drain_timeout: %0d entries left, want 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   // Count LED=FF cycles over one full PWM period for a given brightness.
   task automatic pwm_window(input logic [PWM_BITS-1:0] b, input int want);
      int on_cnt = 0;
      bright = b;
      repeat (2) @(posedge clk);
      repeat (16) begin
         @(posedge clk);
         #1;
         if (led == 8'hFF) on_cnt++;
      end
      check_output("pwm_on_cycles", 8'(on_cnt), 8'(want));
   endtask

   // Monitor: each STEP checks its spacing, then the LED one cycle later
   // is compared against the next queued expectation.
   always @(negedge clk) begin
      if (!rst_n) begin
         since_step = 0;
         led_due    = 1'b0;
      end else begin
         since_step++;
         if (led_due) begin
            led_due = 1'b0;
            if (exp_q.size() > 0) check_output("led_seq", led, exp_q.pop_front());
         end
         if (step) begin
            check_output("step_gap", 8'(since_step), 8'(TICK_DIV + gap_extra));
            gap_extra  = 0;
            since_step = 0;
            if (exp_q.size() == 0) check_output("step_unexpected", {7'b0, step}, 8'h00);
            else led_due = 1'b1;
         end
      end
   end

   // Directed stimulus sequence.
   initial begin
      rst_n  = 1'b0;
      mode   = 2'b00;
      pause  = 1'b0;
      bright = 4'hF;

      // Reset and blink
      repeat (3) @(posedge clk);
      #1;
      check_output("reset_led", led, 8'h00);
      check_output("reset_step", {7'b0, step}, 8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      exp_q.push_back(8'hFF);
      exp_q.push_back(8'h00);
      @(negedge clk);
      #1;
      rst_n = 1'b1;
      drain(40);

      // Rotate
      for (int i = 0; i < 10; i++) exp_q.push_back(rot_tbl[i]);
      apply_stimulus(2'b01);
      drain(60);

      // Bounce
      for (int i = 0; i < 16; i++) exp_q.push_back(bnc_tbl[i]);
      apply_stimulus(2'b10);
      drain(90);

      // Binary count through wrap, stopping at 05
      for (int i = 0; i < 262; i++) exp_q.push_back(8'(i));
      apply_stimulus(2'b11);
      drain(1100);

      // Pause holds the pattern and delays the next STEP by the pause length
      gap_extra = 10;
      pause = 1'b1;
      repeat (10) begin
         @(posedge clk);
         #1;
         check_output("pause_hold", led, 8'h05);
      end
      exp_q.push_back(8'h06);
      pause = 1'b0;
      drain(20);

      // Bounce to 20 heading right, then asynchronous reset between edges
      for (int i = 0; i < 10; i++) exp_q.push_back(bnc_tbl[i]);
      apply_stimulus(2'b10);
      drain(60);
      check_output("pre_reset_led", led, 8'h20);
      #2;
      rst_n = 1'b0;
      #1;
      check_output("async_reset_led", led, 8'h00);
      check_output("async_reset_step", {7'b0, step}, 8'h00);
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h04);
      repeat (2) @(negedge clk);
      #1;
      rst_n = 1'b1;
      drain(30);

      // PWM on a frozen FF pattern
      exp_q.push_back(8'hFF);
      apply_stimulus(2'b00);
      drain(20);
      pause = 1'b1;
      pwm_window(4'h0, 0);
      pwm_window(4'h8, 8);
      pwm_window(4'hF, 16);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Watchdog in case the design never produces the awaited events.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
